mult_div_sequencer: RTL
=======================

// Module: mult_div_sequencer
// PURPOSE
//  Iterative signed multiply/divide unit with its own sequencing FSM. It serves the MULT/DIV
//  instructions of the multicycle CPU. Control issues a start pulse and waits on busy/done.
//  It then writes HI/LO through hi_lo_write; control no longer counts cycles itself.
//  It sits beside the ALU, between register A/B outputs and the HI/LO registers.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH; internal counter is clog2(WIDTH)+1 bits
// PORTS
//  clock        in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-low reset
//  start        in   1        request; sampled only in IDLE
//  op           in   1        0 = MULT, 1 = DIV; sampled with start
//  operand_a    in   WIDTH    multiplicand / dividend (signed); sampled with start
//  operand_b    in   WIDTH    multiplier / divisor (signed); sampled with start
//  busy         out  1        high in every state except IDLE
//  done         out  1        one-cycle completion pulse
//  hi_lo_write  out  1        one-cycle write strobe for the HI/LO registers; coincides with done unless div_zero
//  hi           out  WIDTH    MULT: product[2W-1:W]; DIV: remainder
//  lo           out  WIDTH    MULT: product[W-1:0]; DIV: quotient
//  div_zero     out  1        high with done when the DIV divisor is 0
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; busy, done, hi_lo_write, div_zero, hi, lo, counter all 0.
//  FSM: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
//   IDLE: if start, latch op/a/b on edge 0 -> PREP. start outside IDLE is ignored, including the DONE cycle.
//   PREP (edge 1): latch operand magnitudes, result signs and zeroed accumulator; counter=0.
//     If op=DIV and b==0 -> DONE with done=1, div_zero=1, hi_lo_write=0; hi/lo unchanged.
//     Otherwise -> ITER.
//   ITER: one unsigned step per edge for exactly WIDTH edges (edges 2..WIDTH+1).
//     MULT: shift-add, accumulator 2*WIDTH bits.
//     DIV: restoring; shift remainder, trial-subtract, set quotient bit.
//     When counter==WIDTH-1 -> FIX.
//   FIX (edge WIDTH+2): apply signs, register hi/lo, enter DONE with done=1, hi_lo_write=1.
//     MULT: 2*WIDTH-bit two's complement product, negated if sign(a)^sign(b).
//     DIV: quotient truncates toward zero (negate if signs differ); remainder takes the sign of the dividend.
//     Overflow case -2^(W-1) / -1: lo = 0x80000000, hi = 0; no exception flagged.
//   DONE: done/hi_lo_write/div_zero high exactly this one cycle; next edge -> IDLE, strobes cleared.
//  Latency (normal op): accept at edge 0; done visible for the cycle after edge WIDTH+2 (34 for WIDTH=32).
//  Latency (div_zero): done visible for the cycle after edge 1.
//  hi/lo hold their last completed value until the next hi_lo_write; outputs change only on entering DONE.
//  Operand ports may change freely after acceptance; only the latched copies are used.
//  Reset mid-operation: aborts at once to IDLE with all outputs 0; no partial hi_lo_write ever issued.
//  All outputs are registered; there is no combinational path from inputs to outputs.
// TESTING
//  1. MULT a=7, b=-3 -> after 34 edges done=1, hi_lo_write=1, hi=FFFFFFFF, lo=FFFFFFEB, div_zero=0.
//  2. MULT a=7FFFFFFF, b=7FFFFFFF -> hi=3FFFFFFF, lo=00000001. MULT a=FFFFFFFF, b=FFFFFFFF -> hi=0, lo=1.
//  3. DIV a=-7, b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1). DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
//  4. DIV a=5, b=0 -> done and div_zero high in the cycle after edge 1; hi_lo_write=0; hi/lo keep prior values; busy drops next cycle.
//  5. start pulsed again during ITER with different operands -> ignored; result matches the first operands; one done pulse only.
//  6. reset low at ITER edge 10 -> busy=0, hi=lo=0 immediately, no done. A following MULT 3*4 gives lo=0000000C, hi=0 at the normal latency.

Source files
------------

// File: rtl/mult_div_sequencer.sv
// Iterative signed MULT/DIV unit with its own sequencing FSM.
// Results are registered into hi/lo, with a one-cycle hi_lo_write strobe.
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             hi_lo_write,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, PREP, ITER, FIX, DONE
  } state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               hlw_q, hlw_d;
  logic               dz_q, dz_d;

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod;
  logic [WIDTH-1:0]   quo, rem;

  // acc holds {partial, multiplier} for MULT and {remainder, quotient} for DIV
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, mag_q};
  assign div_step = diff[WIDTH]
                  ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                  : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                       : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    hlw_d   = 1'b0;
    dz_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = operand_a;
          b_d     = operand_b;
          state_d = PREP;
        end
      end
      PREP: begin
        mag_d  = op_q ? abs_w(b_q) : abs_w(a_q);
        acc_d  = {{WIDTH{1'b0}}, op_q ? abs_w(a_q) : abs_w(b_q)};
        neg_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        rneg_d = a_q[WIDTH-1];
        cnt_d  = '0;
        if (op_q && b_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          dz_d    = 1'b1;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        acc_d = op_q ? div_step : mul_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        hi_d    = op_q ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d    = op_q ? quo : prod[WIDTH-1:0];
        done_d  = 1'b1;
        hlw_d   = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hlw_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hlw_q   <= hlw_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi_lo_write = hlw_q;
  assign div_zero    = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
